// File: rtl/stepper_pkg.sv
// stepper_pkg: shared definitions for the step/dir motion path.
//   state_t            move profiler FSM states
//   DRV8825_*_MIN_CLKS driver timing floors at 50 MHz (STEP high 1.9 us,
//                      DIR/ENABLE-to-STEP setup 650 ns), rounded up to whole clks
//   STEP_DEFAULT_PERIOD at-rest step interval, also used by the fixed-rate stepper
package stepper_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW
    } state_t;

    localparam int DRV8825_PULSE_MIN_CLKS     = 95;
    localparam int DRV8825_DIR_SETUP_MIN_CLKS = 33;
    localparam int STEP_DEFAULT_PERIOD        = 100000;

endpackage

// File: rtl/step_interval_timer.sv
// step_interval_timer: loadable down-counter used to time the SETUP, HIGH and
// LOW phases of a move.
//   clk, rst_n  clock, synchronous active-low reset
//   load        load load_val this edge (takes priority over counting)
//   load_val    cycles to count after the load edge
//   expire      counter is at zero; a load of N makes expire high in the
//               (N+1)th cycle after the load edge
module step_interval_timer #(
    parameter int PER_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [PER_W-1:0] load_val,
    output logic             expire
);

    logic [PER_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/stepper_move_profiler.sv
// stepper_move_profiler: accepts a move command (step count + direction) and
// emits that many STEP pulses to a DRV8825 with a linear period ramp
// (accelerate, cruise, decelerate), then releases ENABLE.
//   clk, rst_n        clock, synchronous active-low reset
//   cmd_valid/ready   move command handshake; ready only while idle
//   cmd_steps/dir     steps to move (0 = null move), direction (0=CW, 1=CCW)
//   abort             stop the current move immediately (ignored when idle)
//   step/dir/enable_n DRV8825 STEP, DIR, ENABLE (active low)
//   busy              high from accept to move end
//   done              one-cycle pulse at every move end (normal, abort, null)
//   steps_left        steps still to emit
//   position          (only with STEPPER_POS_TRACK_EN defined) signed step
//                     position, +1 per CW rise, -1 per CCW rise, wrapping
module stepper_move_profiler
    import stepper_pkg::*;
#(
    parameter int STEP_W       = 16,
    parameter int PER_W        = 20,
    parameter int START_PERIOD = STEP_DEFAULT_PERIOD,
    parameter int MIN_PERIOD   = 10000,
    parameter int ACCEL_DELTA  = 100,
    parameter int PULSE_W      = 100,
    parameter int DIR_SETUP    = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              cmd_dir,
    input  logic              abort,
    output logic              step,
    output logic              dir,
    output logic              enable_n,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_left
`ifdef STEPPER_POS_TRACK_EN
    ,
    output logic signed [31:0] position
`endif
);

    localparam logic [PER_W:0]   START_X = (PER_W+1)'(START_PERIOD);
    localparam logic [PER_W:0]   ACC_X   = (PER_W+1)'(ACCEL_DELTA);
    localparam logic [PER_W:0]   FLOOR_X = (PER_W+1)'(MIN_PERIOD + ACCEL_DELTA);
    localparam logic [PER_W-1:0] START_P = PER_W'(START_PERIOD);

    state_t state, state_nxt;

    logic [PER_W-1:0]  period;
    logic [STEP_W-1:0] accel_cnt;

    logic              tmr_load, tmr_exp;
    logic [PER_W-1:0]  tmr_val;
    logic              rise, fall, finish;

    step_interval_timer #(.PER_W(PER_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_exp)
    );

    assign cmd_ready = (state == S_IDLE);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        rise      = 1'b0;
        fall      = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_steps != '0) begin
                    state_nxt = S_SETUP;
                    tmr_load  = 1'b1;
                    tmr_val   = PER_W'(DIR_SETUP);
                end
            end
            S_SETUP: begin
                if (abort) begin
                    finish    = 1'b1;
                    state_nxt = S_IDLE;
                end else if (tmr_exp) begin
                    rise      = 1'b1;
                    state_nxt = S_HIGH;
                    tmr_load  = 1'b1;
                    tmr_val   = PER_W'(PULSE_W - 1);
                end
            end
            S_HIGH: begin
                if (abort) begin
                    finish    = 1'b1;
                    state_nxt = S_IDLE;
                end else if (tmr_exp) begin
                    fall      = 1'b1;
                    state_nxt = S_LOW;
                    tmr_load  = 1'b1;
                    // Last pulse gets a fixed PULSE_W tail; otherwise the low
                    // time makes rise-to-rise equal the freshly updated period.
                    if (steps_left == '0)
                        tmr_val = PER_W'(PULSE_W - 1);
                    else
                        tmr_val = period - PER_W'(PULSE_W + 1);
                end
            end
            S_LOW: begin
                if (abort) begin
                    finish    = 1'b1;
                    state_nxt = S_IDLE;
                end else if (tmr_exp) begin
                    if (steps_left == '0) begin
                        finish    = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        rise      = 1'b1;
                        state_nxt = S_HIGH;
                        tmr_load  = 1'b1;
                        tmr_val   = PER_W'(PULSE_W - 1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ----------------------------------------------------- ramp arithmetic
    // Evaluated with the post-decrement remaining count, so decel starts
    // once the steps left no longer exceed the steps spent accelerating.
    logic [STEP_W-1:0] left_dec, accel_upd;
    logic [PER_W-1:0]  period_upd;
    logic [PER_W:0]    per_up;

    always_comb begin
        left_dec   = steps_left - 1'b1;
        per_up     = {1'b0, period} + ACC_X;
        period_upd = period;
        accel_upd  = accel_cnt;
        if (left_dec <= accel_cnt) begin
            period_upd = (per_up > START_X) ? START_P : per_up[PER_W-1:0];
            accel_upd  = (accel_cnt == '0) ? '0 : accel_cnt - 1'b1;
        end else if ({1'b0, period} >= FLOOR_X) begin
            period_upd = period - PER_W'(ACCEL_DELTA);
            accel_upd  = (accel_cnt == '1) ? accel_cnt : accel_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step       <= 1'b0;
            dir        <= 1'b0;
            enable_n   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            steps_left <= '0;
            period     <= START_P;
            accel_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE && cmd_valid) begin
                if (cmd_steps == '0) begin
                    done <= 1'b1;
                end else begin
                    steps_left <= cmd_steps;
                    dir        <= cmd_dir;
                    enable_n   <= 1'b0;
                    busy       <= 1'b1;
                    // Every move starts from rest, even after an abort.
                    period     <= START_P;
                    accel_cnt  <= '0;
                end
            end
            if (rise) begin
                step       <= 1'b1;
                steps_left <= left_dec;
                period     <= period_upd;
                accel_cnt  <= accel_upd;
            end
            if (fall)
                step <= 1'b0;
            if (finish) begin
                step       <= 1'b0;
                done       <= 1'b1;
                busy       <= 1'b0;
                enable_n   <= 1'b1;
                steps_left <= '0;
            end
        end
    end

`ifdef STEPPER_POS_TRACK_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            position <= '0;
        else if (rise)
            position <= dir ? position - 32'sd1 : position + 32'sd1;
    end
`endif

endmodule

// File: tb/tb_stepper_move_profiler.sv
module tb_stepper_move_profiler;

    localparam int STEP_W    = 16;
    localparam int PER_W     = 20;
    localparam int START     = 1000;
    localparam int MINP      = 400;
    localparam int ACC       = 200;
    localparam int PULSE_W   = 10;
    localparam int DIR_SETUP = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [STEP_W-1:0] cmd_steps = '0;
    logic              cmd_dir = 1'b0;
    logic              abort = 1'b0;
    logic              step, dir, enable_n, busy, done;
    logic [STEP_W-1:0] steps_left;
`ifdef STEPPER_POS_TRACK_EN
    logic signed [31:0] position;
`endif

    stepper_move_profiler #(
        .STEP_W(STEP_W), .PER_W(PER_W), .START_PERIOD(START), .MIN_PERIOD(MINP),
        .ACCEL_DELTA(ACC), .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .abort(abort), .step(step),
        .dir(dir), .enable_n(enable_n), .busy(busy), .done(done),
        .steps_left(steps_left)
`ifdef STEPPER_POS_TRACK_EN
        , .position(position)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Edge monitor: timestamps of STEP rises/falls and done pulses.
    int   rise_q[$];
    int   fall_q[$];
    int   done_q[$];
    logic step_q = 1'b0;
    always @(negedge clk) begin
        if (step === 1'b1 && step_q === 1'b0) rise_q.push_back(cyc);
        if (step === 1'b0 && step_q === 1'b1) fall_q.push_back(cyc);
        if (done === 1'b1) done_q.push_back(cyc);
        step_q = step;
    end

    int ncmp = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    // Reference ramp: interval following each rise, from the move rules.
    int exp_iv[$];
    function automatic void model_intervals(input int n);
        int per, acc, left;
        per = START;
        acc = 0;
        exp_iv.delete();
        for (int k = 1; k <= n; k++) begin
            left = n - k;
            if (left <= acc) begin
                per = (per + ACC > START) ? START : per + ACC;
                acc = (acc > 0) ? acc - 1 : 0;
            end else if (per - ACC >= MINP) begin
                per = per - ACC;
                acc = acc + 1;
            end
            exp_iv.push_back(per);
        end
    endfunction

    task automatic clear_mon();
        rise_q.delete();
        fall_q.delete();
        done_q.delete();
    endtask

    task automatic wait_done(input int n);
        int lim;
        lim = DIR_SETUP + (n + 2) * START + 100;
        for (int i = 0; i < lim; i++) begin
            if (done === 1'b1) break;
            nstep();
        end
        chk("done_seen", 32'(done), 1);
    endtask

    task automatic run_move(input int n, input bit d);
        int a;
        chk("ready_idle", 32'(cmd_ready), 1);
        clear_mon();
        cmd_valid = 1'b1;
        cmd_steps = STEP_W'(n);
        cmd_dir   = d;
        nstep();
        a = cyc;
        cmd_valid = 1'b0;
        chk("dir_latched", 32'(dir), 32'(d));
        chk("enable_on", 32'(enable_n), 0);
        chk("busy_on", 32'(busy), 1);
        chk("ready_busy", 32'(cmd_ready), 0);
        chk("left_start", 32'(steps_left), n);
        wait_done(n);
        chk("end_busy", 32'(busy), 0);
        chk("end_enable", 32'(enable_n), 1);
        chk("end_left", 32'(steps_left), 0);
        model_intervals(n);
        chk("rise_count", rise_q.size(), n);
        chk("fall_count", fall_q.size(), n);
        if (rise_q.size() == n && fall_q.size() == n && done_q.size() > 0) begin
            chk("first_rise", rise_q[0] - a, DIR_SETUP + 1);
            for (int k = 0; k < n; k++) begin
                chk("pulse_w", fall_q[k] - rise_q[k], PULSE_W);
                if (k > 0) chk("interval", rise_q[k] - rise_q[k-1], exp_iv[k-1]);
            end
            chk("done_tail", done_q[0] - fall_q[n-1], PULSE_W);
        end
        nstep();
        chk("done_once", done_q.size(), 1);
    endtask

    initial begin
        int bad, n;
        bit d;

        // Reset state
        nstep();
        nstep();
        chk("rst_step", 32'(step), 0);
        chk("rst_dir", 32'(dir), 0);
        chk("rst_enable", 32'(enable_n), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_left", 32'(steps_left), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
`ifdef STEPPER_POS_TRACK_EN
        chk("rst_pos", 32'(position), 0);
`endif
        rst_n = 1'b1;
        nstep();

        // abort while idle does nothing
        abort = 1'b1;
        nstep();
        abort = 1'b0;
        chk("idle_abort_done", 32'(done), 0);
        chk("idle_abort_busy", 32'(busy), 0);

        // Triangular ramp (5 steps, CCW) and trapezoid with cruise (20 steps)
        run_move(5, 1'b1);
        run_move(20, 1'b0);

        // Null move
        clear_mon();
        cmd_valid = 1'b1;
        cmd_steps = '0;
        nstep();
        cmd_valid = 1'b0;
        chk("null_done", 32'(done), 1);
        chk("null_busy", 32'(busy), 0);
        chk("null_enable", 32'(enable_n), 1);
        chk("null_ready", 32'(cmd_ready), 1);
        nstep();
        chk("null_done_pulse", 32'(done), 0);
        for (int i = 0; i < 20; i++) nstep();
        chk("null_no_step", rise_q.size(), 0);
        chk("null_enable_hold", 32'(enable_n), 1);

        // Random moves
        for (int r = 0; r < 3; r++) begin
            n = int'($urandom_range(1, 12));
            d = 1'($urandom_range(0, 1));
            run_move(n, d);
        end

        // Reset in the middle of a STEP high phase
        clear_mon();
        cmd_valid = 1'b1;
        cmd_steps = 16'd3;
        cmd_dir   = 1'b1;
        nstep();
        cmd_valid = 1'b0;
        for (int i = 0; i < 2 * START; i++) begin
            if (step === 1'b1) break;
            nstep();
        end
        chk("rst_pre_high", 32'(step), 1);
        rst_n = 1'b0;
        nstep();
        chk("midrst_step", 32'(step), 0);
        chk("midrst_enable", 32'(enable_n), 1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ready", 32'(cmd_ready), 1);
        rst_n = 1'b1;
        nstep();

        // Abort in the 3rd HIGH cycle of step 2 of 10
        clear_mon();
        cmd_valid = 1'b1;
        cmd_steps = 16'd10;
        cmd_dir   = 1'b0;
        nstep();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3 * START; i++) begin
            if (rise_q.size() >= 2) break;
            nstep();
        end
        chk("abort_rise2", rise_q.size(), 2);
        chk("abort_left8", 32'(steps_left), 8);
        nstep();
        nstep();
        abort = 1'b1;
        nstep();
        abort = 1'b0;
        chk("abort_step", 32'(step), 0);
        chk("abort_done", 32'(done), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_left", 32'(steps_left), 0);
        chk("abort_enable", 32'(enable_n), 1);
`ifdef STEPPER_POS_TRACK_EN
        chk("abort_pos", 32'(position), 2);
`endif
        nstep();
        chk("abort_done_pulse", 32'(done), 0);
        chk("abort_done_once", done_q.size(), 1);

        // Abort coincident with normal completion of a 1-step move
        clear_mon();
        cmd_valid = 1'b1;
        cmd_steps = 16'd1;
        nstep();
        cmd_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (fall_q.size() >= 1) break;
            nstep();
        end
        for (int i = 0; i < PULSE_W - 1; i++) nstep();
        chk("coinc_pre_done", 32'(done), 0);
        abort = 1'b1;
        nstep();
        abort = 1'b0;
        chk("coinc_done", 32'(done), 1);
        for (int i = 0; i < 5; i++) nstep();
        chk("coinc_done_once", done_q.size(), 1);
        chk("coinc_busy", 32'(busy), 0);

        // cmd_valid held through a move: ignored while busy, next move
        // accepted on the edge after done
        clear_mon();
        cmd_valid = 1'b1;
        cmd_steps = 16'd2;
        cmd_dir   = 1'b0;
        nstep();
        bad = 0;
        for (int i = 0; i < 4 * START; i++) begin
            if (done === 1'b1) break;
            if (busy === 1'b1 && cmd_ready !== 1'b0) bad++;
            nstep();
        end
        chk("held_ready_low", bad, 0);
        chk("held_done", 32'(done), 1);
        chk("held_ready_at_done", 32'(cmd_ready), 1);
        chk("held_rises", rise_q.size(), 2);
        nstep();
        cmd_valid = 1'b0;
        chk("held_second_accept", 32'(busy), 1);
        chk("held_second_left", 32'(steps_left), 2);
        wait_done(2);
        nstep();
        chk("held_total_rises", rise_q.size(), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
